// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the unified-memory arbiter.
//   state_e    : arbiter FSM states (IDLE, DBUS, IBUS)
//   SZ_*       : data access size codes carried on idsize
//   BE_*       : unshifted byte-enable patterns for each access size
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DBUS = 2'b01,
      IBUS = 2'b10
   } state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 32-bit memory.
//   size_i   : access size (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 acts as word)
//   lane_i   : byte address bits [1:0]
//   signed_i : sign-extend load results
//   wdata_i  : LSB-aligned store data
//   rdata_i  : raw memory read word
//   be_o     : byte enables for the access
//   wdata_o  : store data replicated across all lanes
//   rdata_o  : selected lane(s) shifted to bit 0, zero/sign-extended
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  lane_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Half-words ignore lane_i[0]: misaligned halves are truncated to the aligned pair.
   assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
   assign half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];

   always_comb begin
      be_o    = BE_WORD;
      wdata_o = wdata_i;
      rdata_o = rdata_i;
      case (size_i)
         SZ_BYTE: begin
            be_o    = BE_BYTE << lane_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
         end
         SZ_HALF: begin
            be_o    = BE_HALF << {lane_i[1], 1'b0};
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{signed_i & half_sel[15]}}, half_sel};
         end
         default: begin
            // Word and the illegal code both pass straight through.
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and data ports.
// Data requests win over fetches. A transfer is latched in IDLE, issued on omem_*
// until imem_ack (or the watchdog fires), and its valid pulses the cycle after.
//   iclk/irst            : clock, asynchronous active-high reset
//   iireq/iiaddr         : fetch request; oirdata/oivalid/oistall fetch response
//   idreq/idwe/idsize/idsigned/idaddr/idwdata : data request
//   odrdata/odvalid/odstall : data response
//   oerr                 : abort pulse (timeout, or misalignment trap)
//   omem_*/imem_*        : shared memory interface
// Optional feature: define MEM_ARBITER_MISALIGN_TRAP_EN to trap misaligned
// half/word data accesses instead of truncating their addresses.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned MP_DATA_WIDTH = 32,
   parameter int unsigned MP_ADDR_WIDTH = 32,
   parameter int unsigned MP_TIMEOUT    = 15
) (
   input  logic                     iclk,
   input  logic                     irst,
   input  logic                     iireq,
   input  logic [MP_ADDR_WIDTH-1:0] iiaddr,
   output logic [MP_DATA_WIDTH-1:0] oirdata,
   output logic                     oivalid,
   output logic                     oistall,
   input  logic                     idreq,
   input  logic                     idwe,
   input  logic [1:0]               idsize,
   input  logic                     idsigned,
   input  logic [MP_ADDR_WIDTH-1:0] idaddr,
   input  logic [MP_DATA_WIDTH-1:0] idwdata,
   output logic [MP_DATA_WIDTH-1:0] odrdata,
   output logic                     odvalid,
   output logic                     odstall,
   output logic                     oerr,
   output logic                     omem_req,
   output logic                     omem_we,
   output logic [3:0]               omem_be,
   output logic [MP_ADDR_WIDTH-1:0] omem_addr,
   output logic [MP_DATA_WIDTH-1:0] omem_wdata,
   input  logic [MP_DATA_WIDTH-1:0] imem_rdata,
   input  logic                     imem_ack
);

   localparam int unsigned     CntW    = $clog2(MP_TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(MP_TIMEOUT - 1);

   state_e                   state_q, state_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic                     we_q, we_d;
   logic [3:0]               be_q, be_d;
   logic [MP_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [MP_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]               size_q, size_d;
   logic [1:0]               lane_q, lane_d;
   logic                     signed_q, signed_d;
   logic                     ivalid_q, ivalid_d;
   logic                     dvalid_q, dvalid_d;
   logic                     err_q, err_d;
   logic [MP_DATA_WIDTH-1:0] irdata_q, irdata_d;
   logic [MP_DATA_WIDTH-1:0] drdata_q, drdata_d;

   logic                     busy;
   logic                     tmo_hit;
   logic                     dbus_done;
   logic                     ibus_done;
   logic                     trap_now;
   logic [1:0]               al_size;
   logic [1:0]               al_lane;
   logic                     al_signed;
   logic [3:0]               al_be;
   logic [MP_DATA_WIDTH-1:0] al_wdata;
   logic [MP_DATA_WIDTH-1:0] al_rdata;
   logic                     unused_iiaddr;

   // Fetches are word-aligned; their low address bits carry no information.
   assign unused_iiaddr = ^iiaddr[1:0];

   assign busy      = (state_q != IDLE);
   assign tmo_hit   = busy & ~imem_ack & (cnt_q == CntLast);
   assign dbus_done = (state_q == DBUS) & (imem_ack | tmo_hit);
   assign ibus_done = (state_q == IBUS) & (imem_ack | tmo_hit);

`ifdef MEM_ARBITER_MISALIGN_TRAP_EN
   logic misalign;
   always_comb begin
      misalign = 1'b0;
      case (idsize)
         SZ_BYTE: misalign = 1'b0;
         SZ_HALF: misalign = idaddr[0];
         default: misalign = |idaddr[1:0];
      endcase
   end
   assign trap_now = (state_q == IDLE) & idreq & misalign;
`else
   assign trap_now = 1'b0;
`endif

   // Lane logic sees the live request while latching and the latched one while
   // the transfer is in flight, so one instance serves both directions.
   assign al_size   = busy ? size_q   : idsize;
   assign al_lane   = busy ? lane_q   : idaddr[1:0];
   assign al_signed = busy ? signed_q : idsigned;

   mem_lane_align u_lane_align (
      .size_i   (al_size),
      .lane_i   (al_lane),
      .signed_i (al_signed),
      .wdata_i  (idwdata),
      .rdata_i  (imem_rdata),
      .be_o     (al_be),
      .wdata_o  (al_wdata),
      .rdata_o  (al_rdata)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      be_d     = be_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      lane_d   = lane_q;
      signed_d = signed_q;
      ivalid_d = 1'b0;
      dvalid_d = 1'b0;
      err_d    = 1'b0;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (trap_now) begin
               // Never reaches memory: complete with an error straight away.
               dvalid_d = 1'b1;
               err_d    = 1'b1;
               drdata_d = '0;
            end else if (idreq) begin
               state_d  = DBUS;
               we_d     = idwe;
               be_d     = al_be;
               addr_d   = {idaddr[MP_ADDR_WIDTH-1:2], 2'b00};
               wdata_d  = al_wdata;
               size_d   = idsize;
               lane_d   = idaddr[1:0];
               signed_d = idsigned;
            end else if (iireq) begin
               state_d = IBUS;
               we_d    = 1'b0;
               be_d    = BE_WORD;
               addr_d  = {iiaddr[MP_ADDR_WIDTH-1:2], 2'b00};
               wdata_d = '0;
            end
         end
         DBUS, IBUS: begin
            if (imem_ack || tmo_hit) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = tmo_hit;
               if (state_q == DBUS) begin
                  dvalid_d = 1'b1;
                  drdata_d = (tmo_hit || we_q) ? '0 : al_rdata;
               end else begin
                  ivalid_d = 1'b1;
                  irdata_d = tmo_hit ? '0 : imem_rdata;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         be_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= '0;
         lane_q   <= '0;
         signed_q <= 1'b0;
         ivalid_q <= 1'b0;
         dvalid_q <= 1'b0;
         err_q    <= 1'b0;
         irdata_q <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         be_q     <= be_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         lane_q   <= lane_d;
         signed_q <= signed_d;
         ivalid_q <= ivalid_d;
         dvalid_q <= dvalid_d;
         err_q    <= err_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
      end
   end

   // Memory-side outputs are gated so they read 0 whenever nothing is in flight.
   assign omem_req   = busy;
   assign omem_we    = busy & we_q;
   assign omem_be    = busy ? be_q : 4'b0000;
   assign omem_addr  = busy ? addr_q : '0;
   assign omem_wdata = busy ? wdata_q : '0;

   // Stalls are combinational on the requests; reset forces them low too.
   assign odstall = idreq & ~irst & ~(dbus_done | trap_now);
   assign oistall = iireq & ~irst & ~ibus_done;

   assign oivalid = ivalid_q;
   assign odvalid = dvalid_q;
   assign oerr    = err_q;
   assign oirdata = irdata_q;
   assign odrdata = drdata_q;

endmodule
